mult_stream: RTL and testbench
==============================

Name: mult_stream

Overview:
- Parametrised streaming multiplier with a valid/ready handshake on both sides.
- Supports per-transaction signed or unsigned mode, carries a sideband tag, and lets bubbles collapse through a configurable-depth pipeline.
- It is the next-generation datapath multiplier. It replaces fixed-latency, free-running multipliers in compute blocks that need backpressure.
- Sits between an operand-issue FIFO and a result consumer.

Parameters:
- W, 16, operand width in bits; even, ≥4.
- STAGES, 3, pipeline depth and also zero-stall latency in cycles; ≥2.
- TAG_W, 4, sideband tag width carried alongside each product; ≥1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  W  multiplicand.
- in_b  input  W  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  input  TAG_W  sideband tag, returned with the result.
- flush  input  1  synchronous pipeline clear.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- out_product  output  2W  product.
- out_tag  output  TAG_W  tag of this product.
- busy  output  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits clear.
  - out_valid=0, out_product=0, out_tag=0, busy=0.
  - in_ready=1 from the first cycle after release.
- Pipeline: STAGES register stages S1..SN, each holding {valid, data, tag, signed}.
  - Stage k advances when (Sk+1 empty) OR (Sk+1 advancing); SN advances when out_ready OR !out_valid.
  - in_ready = S1 empty OR S1 advancing (bubble-collapsing).
  - A beat is accepted on in_valid && in_ready.
- Latency: exactly STAGES cycles from acceptance to out_valid when never stalled. Throughput is 1 beat/cycle.
- Datapath split:
  - S1 registers the two partial products P_lo = a × b[W/2-1:0] (b_lo always unsigned) and P_hi = a × b[W-1:W/2].
  - In signed mode P_hi uses signed b_hi and a; in unsigned mode both are unsigned. Operands are extended to W+1 bits as needed.
  - S2 forms P_hi·2^(W/2) + P_lo, truncated to 2W bits.
  - S3..SN are delay registers.
- Arithmetic rules:
  - Unsigned result equals a·b mod 2^(2W).
  - Signed result equals two's-complement a·b in 2W bits.
  - The full product always fits: (−2^(W−1))² = 2^(2W−2) must be exact.
- Output stability: while out_valid && !out_ready, out_product and out_tag hold stable and no beat is lost or duplicated.
- Ordering: results leave in acceptance order; tags are never reordered.
- flush:
  - In the cycle flush=1, all valid bits clear at the next edge.
  - in_ready=0 that cycle, and any in_valid is not accepted.
  - out_valid drops the next cycle. Data registers need not clear.
- flush together with out_valid && out_ready in the same cycle: the output beat counts as consumed; all others are discarded.
- busy = OR of all stage valid bits, registered-free (combinational from state).
- Reset mid-operation: all in-flight beats are discarded with no output.

Optional Feature:
- Macro: MULT_STREAM_ACC_EN.
- When defined:
  - Adds port in_acc_clr (input, 1) and parameter ACC_W (default 2W+8).
  - out_product widens to ACC_W.
  - A running accumulator in SN: on each output handshake, acc ← (clr_of_beat ? 0 : acc) + sign/zero-extended product, wrapping mod 2^ACC_W.
  - out_product shows acc including the current beat.
  - Reset and flush zero the accumulator.
- When undefined: out_product is the plain 2W product, with no accumulator logic or ports.

Test Plan:
- W=16, STAGES=3, unsigned: a=0xFFFF, b=0xFFFF, tag=5, out_ready=1 → out_valid exactly 3 cycles later, product=0xFFFE0001, tag=5.
- Signed: a=0x8000, b=0x8000 → 0x40000000; a=0xFFFF(−1), b=0x0003 → 0xFFFFFFFD.
- Back-to-back 8 beats with random operands, then out_ready held 0 for 5 cycles mid-stream:
  - in_ready drops only once all 3 stages are full.
  - Outputs match a model in order, with stable data while stalled and no loss.
- Bubble collapse: accept beat 0, idle 1 cycle, accept beat 1, out_ready=0 → both beats end up packed in S3/S2 and in_ready stays 1 for S1.
- flush asserted with 3 beats in flight and in_valid=1 → no output beats ever appear, busy=0 next cycle, the beat offered during flush is not accepted.
- Reset asserted asynchronously mid-stream → out_valid=0 immediately; after release, a=3, b=7 gives 21 after 3 cycles.
- With MULT_STREAM_ACC_EN: products 2×3, 4×5 (clr on the first beat) → outputs 6 then 26.

Source files
------------

// File: rtl/mult_stream.sv
// ---------------------------------------------------------------------------
// mult_stream
//
// Streaming multiplier with valid/ready on both sides. Each beat carries its
// own signed/unsigned mode and a sideband tag. The pipeline is STAGES deep
// and collapses bubbles, so backpressure only reaches the input once every
// stage holds a beat.
//
//   S1      : registers the two partial products a*b_lo and a*b_hi
//   S2      : combines them into the 2W-bit product
//   S3..SN  : plain delay stages
//
// Parameters
//   W       operand width (even, >= 4)
//   STAGES  pipeline depth = zero-stall latency (>= 2)
//   TAG_W   sideband tag width (>= 1)
//   ACC_W   accumulator width (only with MULT_STREAM_ACC_EN)
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   in_valid/in_ready operand beat handshake
//   in_a, in_b        multiplicand / multiplier
//   in_signed         1 = two's-complement operands, 0 = unsigned
//   in_tag            tag returned alongside the product
//   in_acc_clr        (MULT_STREAM_ACC_EN only) restart accumulation on this beat
//   flush             synchronous clear of every in-flight beat
//   out_valid/out_ready result handshake
//   out_product       product, or the running accumulator when
//                     MULT_STREAM_ACC_EN is defined
//   out_tag           tag of the beat on the output
//   busy              at least one stage holds a valid beat
//
// Build option
//   MULT_STREAM_ACC_EN  adds a running accumulator in the last stage.
// ---------------------------------------------------------------------------
module mult_stream #(
    parameter int W      = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
`ifdef MULT_STREAM_ACC_EN
    ,
    parameter int ACC_W  = 2*W + 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
`ifdef MULT_STREAM_ACC_EN
    input  logic             in_acc_clr,
`endif
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MULT_STREAM_ACC_EN
    output logic [ACC_W-1:0] out_product,
`else
    output logic [2*W-1:0]   out_product,
`endif
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PW   = 2*W;
    // Signed (W+1)-bit by signed (W/2+1)-bit product needs 3W/2+2 bits.
    localparam int PP_W = W + W/2 + 2;

    // Stage state. Index 0 is S1, index STAGES-1 is SN.
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] move;
    logic [TAG_W-1:0]  tag  [STAGES];
    // prod[k-1] is the product held by stage k (k >= 1, i.e. S2..SN).
    logic [PW-1:0]     prod [STAGES-1];

    logic signed [PP_W-1:0] s1_plo;
    logic signed [PP_W-1:0] s1_phi;

    logic signed [W:0]      a_ext;
    logic signed [W/2:0]    b_lo_ext;
    logic signed [W/2:0]    b_hi_ext;
    logic signed [PP_W-1:0] plo_next;
    logic signed [PP_W-1:0] phi_next;
    logic [PW-1:0]          s1_sum;

    // Operands are widened by one bit so a single signed multiplier covers
    // both modes: in unsigned mode the extra bit is zero, in signed mode it
    // is the sign. The low half of b is always a magnitude.
    assign a_ext    = {in_signed & in_a[W-1], in_a};
    assign b_lo_ext = {1'b0, in_b[W/2-1:0]};
    assign b_hi_ext = {in_signed & in_b[W-1], in_b[W-1:W/2]};
    assign plo_next = PP_W'(a_ext) * PP_W'(b_lo_ext);
    assign phi_next = PP_W'(a_ext) * PP_W'(b_hi_ext);

    // Recombine the partial products; wrapping at 2W bits gives the correct
    // two's-complement or modular result.
    assign s1_sum = (PW'(s1_phi) << (W/2)) + PW'(s1_plo);

    // A stage passes its content on when the output side will take it:
    // SN moves when the consumer accepts or SN is empty; every earlier stage
    // moves when some stage below it has a hole or the output is draining.
    always_comb begin
        logic room;
        move = '0;
        room = out_ready || !valid[STAGES-1];
        for (int k = STAGES-1; k >= 0; k--) begin
            if (k < STAGES-1) begin
                room = room || !valid[k+1];
            end
            move[k] = room;
        end
    end

    assign in_ready  = !flush && (!valid[0] || move[0]);
    assign out_valid = valid[STAGES-1];
    assign out_tag   = tag[STAGES-1];
    assign busy      = |valid;

`ifdef MULT_STREAM_ACC_EN
    logic [STAGES-1:0] sgn;
    logic [STAGES-1:0] clr;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_sum;

    // The output shows the accumulator including the beat currently in SN;
    // the stored value only commits when that beat is handed off.
    always_comb begin
        prod_ext = sgn[STAGES-1] ? ACC_W'($signed(prod[STAGES-2]))
                                 : ACC_W'(prod[STAGES-2]);
        acc_sum  = (clr[STAGES-1] ? '0 : acc) + prod_ext;
    end

    assign out_product = acc_sum;

    // Accumulator commit on each output handshake; flush restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (flush) begin
            acc <= '0;
        end else if (valid[STAGES-1] && out_ready) begin
            acc <= acc_sum;
        end
    end

    // Mode and clear bits travel with each beat so SN knows how to extend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn <= '0;
            clr <= '0;
        end else begin
            if (in_ready) begin
                sgn[0] <= in_signed;
                clr[0] <= in_acc_clr;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (move[k-1]) begin
                    sgn[k] <= sgn[k-1];
                    clr[k] <= clr[k-1];
                end
            end
        end
    end
`else
    assign out_product = prod[STAGES-2];
`endif

    // Pipeline registers. Each stage loads from the one above whenever that
    // stage moves; a flush then overrides every valid bit while the data
    // registers are left as they are.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            s1_plo <= '0;
            s1_phi <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tag[k] <= '0;
            end
            for (int k = 0; k < STAGES-1; k++) begin
                prod[k] <= '0;
            end
        end else begin
            if (in_ready) begin
                valid[0] <= in_valid;
                tag[0]   <= in_tag;
                s1_plo   <= plo_next;
                s1_phi   <= phi_next;
            end
            if (move[0]) begin
                valid[1] <= valid[0];
                tag[1]   <= tag[0];
                prod[0]  <= s1_sum;
            end
            for (int k = 2; k < STAGES; k++) begin
                if (move[k-1]) begin
                    valid[k]  <= valid[k-1];
                    tag[k]    <= tag[k-1];
                    prod[k-1] <= prod[k-2];
                end
            end
            if (flush) begin
                valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mult_stream.sv
// ---------------------------------------------------------------------------
// tb_mult_stream
//
// Directed bench for mult_stream with W=16, STAGES=3, TAG_W=4. Covers reset
// values, latency, unsigned and signed corner products, a stalled back-to-back
// stream, bubble collapse, flush, asynchronous reset and, when
// MULT_STREAM_ACC_EN is defined, accumulation across beats.
// ---------------------------------------------------------------------------
module tb_mult_stream;

    localparam int W      = 16;
    localparam int STAGES = 3;
    localparam int TAG_W  = 4;
`ifdef MULT_STREAM_ACC_EN
    localparam int OUT_W  = 2*W + 8;
`else
    localparam int OUT_W  = 2*W;
`endif

    logic             clock;
    logic             reset;
    logic             inValid;
    logic             inReady;
    logic [W-1:0]     inA;
    logic [W-1:0]     inB;
    logic             inSigned;
    logic [TAG_W-1:0] inTag;
    logic             inAccClr;
    logic             flush;
    logic             outValid;
    logic             outReady;
    logic [OUT_W-1:0] outProduct;
    logic [TAG_W-1:0] outTag;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    mult_stream #(
        .W      (W),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk         (clock),
        .rst         (reset),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .in_a        (inA),
        .in_b        (inB),
        .in_signed   (inSigned),
        .in_tag      (inTag),
`ifdef MULT_STREAM_ACC_EN
        .in_acc_clr  (inAccClr),
`endif
        .flush       (flush),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_product (outProduct),
        .out_tag     (outTag),
        .busy        (busy)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Places one operand beat on the input bus (valid is driven separately).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic [TAG_W-1:0] t);
        inA      = a;
        inB      = b;
        inSigned = s;
        inTag    = t;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference product, computed with wide integer arithmetic.
    function automatic logic [2*W-1:0] expProd(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s);
        longint pa;
        longint pb;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return (2*W)'(pa * pb);
    endfunction

    // One isolated beat: checks acceptance, latency, product and tag.
    task automatic runSingle(input string name, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic s,
                             input logic [TAG_W-1:0] t,
                             input logic [2*W-1:0] expected);
        int lat;
        outReady = 1'b1;
        applyStimulus(a, b, s, t);
        inValid = 1'b1;
        #1;
        checkOutput({name, "_inready"}, 64'(inReady), 64'd1);
        tick();
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'd3);
        checkOutput({name, "_product"}, 64'(outProduct[2*W-1:0]), 64'(expected));
        checkOutput({name, "_tag"}, 64'(outTag), 64'(t));
        tick();
    endtask

    // Waits (bounded) for an output beat with outReady high and checks it.
    task automatic expectOut(input string name, input logic [2*W-1:0] expected,
                             input logic [TAG_W-1:0] t);
        int wait_cycles;
        outReady = 1'b1;
        wait_cycles = 0;
        while (!outValid && wait_cycles < 10) begin
            tick();
            wait_cycles++;
        end
        checkOutput({name, "_valid"}, 64'(outValid), 64'd1);
        checkOutput({name, "_product"}, 64'(outProduct[2*W-1:0]), 64'(expected));
        checkOutput({name, "_tag"}, 64'(outTag), 64'(t));
        tick();
    endtask

    // Stimulus for the back-to-back stream; odd beats are signed.
    logic [W-1:0] streamA [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0007,
                                  16'hABCD, 16'h7FFF, 16'h0000, 16'hC001};
    logic [W-1:0] streamB [8] = '{16'h5678, 16'h0002, 16'h8000, 16'hFFF9,
                                  16'h00FF, 16'h8000, 16'h9999, 16'h0101};

    initial begin
        int sent;
        int got;
        int cyc;
        int seen;
        logic wasStalled;
        logic [2*W-1:0] holdP;
        logic [TAG_W-1:0] holdT;

        reset    = 1'b1;
        inValid  = 1'b0;
        inA      = '0;
        inB      = '0;
        inSigned = 1'b0;
        inTag    = '0;
        inAccClr = 1'b1;
        flush    = 1'b0;
        outReady = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_product", 64'(outProduct), 64'd0);
        checkOutput("rst_tag", 64'(outTag), 64'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", 64'(inReady), 64'd1);

        // Isolated beats, unsigned and signed corners
        runSingle("u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 4'd5, 32'hFFFE0001);
        runSingle("s_min_sq", 16'h8000, 16'h8000, 1'b1, 4'd6, 32'h40000000);
        runSingle("s_neg1x3", 16'hFFFF, 16'h0003, 1'b1, 4'd7, 32'hFFFFFFFD);
        runSingle("u_ffffx3", 16'hFFFF, 16'h0003, 1'b0, 4'd8, 32'h0002FFFD);
        runSingle("s_max_min", 16'h7FFF, 16'h8000, 1'b1, 4'd9, 32'hC0008000);

        // Back-to-back stream with a five-cycle output stall
        sent = 0;
        got = 0;
        cyc = 0;
        wasStalled = 1'b0;
        holdP = '0;
        holdT = '0;
        while (got < 8 && cyc < 100) begin
            inValid = (sent < 8);
            if (sent < 8) begin
                applyStimulus(streamA[sent], streamB[sent], sent[0], TAG_W'(sent));
            end
            outReady = !(cyc >= 4 && cyc < 9);
            #1;
            checkOutput("strm_in_ready", 64'(inReady),
                        64'(outReady || (sent - got) < STAGES));
            if (wasStalled) begin
                checkOutput("strm_hold_valid", 64'(outValid), 64'd1);
                checkOutput("strm_hold_product", 64'(outProduct[2*W-1:0]), 64'(holdP));
                checkOutput("strm_hold_tag", 64'(outTag), 64'(holdT));
            end
            wasStalled = outValid && !outReady;
            holdP = outProduct[2*W-1:0];
            holdT = outTag;
            if (outValid && outReady) begin
                checkOutput("strm_product", 64'(outProduct[2*W-1:0]),
                            64'(expProd(streamA[got], streamB[got], got[0])));
                checkOutput("strm_tag", 64'(outTag), 64'(got));
                got++;
            end
            if (inValid && inReady) begin
                sent++;
            end
            tick();
            cyc++;
        end
        inValid = 1'b0;
        checkOutput("strm_count", 64'(got), 64'd8);

        // Bubble collapse: beat, gap, beat, with the output blocked
        outReady = 1'b0;
        applyStimulus(16'd10, 16'd11, 1'b0, 4'd1);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick();
        applyStimulus(16'd12, 16'd13, 1'b0, 4'd2);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick();
        tick();
        checkOutput("bub_out_valid", 64'(outValid), 64'd1);
        checkOutput("bub_out_tag", 64'(outTag), 64'd1);
        checkOutput("bub_in_ready", 64'(inReady), 64'd1);
        checkOutput("bub_busy", 64'(busy), 64'd1);
        expectOut("bub_beat0", 32'd110, 4'd1);
        expectOut("bub_beat1", 32'd156, 4'd2);

        // Flush with three beats in flight and a beat on offer
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'(i + 2), 16'd3, 1'b0, TAG_W'(i + 10));
            inValid = 1'b1;
            tick();
        end
        applyStimulus(16'd9, 16'd9, 1'b0, 4'd15);
        inValid = 1'b1;
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", 64'(inReady), 64'd0);
        checkOutput("flush_busy_before", 64'(busy), 64'd1);
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        checkOutput("flush_busy_after", 64'(busy), 64'd0);
        checkOutput("flush_out_valid", 64'(outValid), 64'd0);
        outReady = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (outValid) begin
                seen++;
            end
            tick();
        end
        checkOutput("flush_no_output", 64'(seen), 64'd0);

        // Asynchronous reset with a beat waiting on the output
        outReady = 1'b0;
        applyStimulus(16'd100, 16'd100, 1'b0, 4'd3);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick();
        tick();
        checkOutput("arst_pre_valid", 64'(outValid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_out_valid", 64'(outValid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        runSingle("arst_3x7", 16'd3, 16'd7, 1'b0, 4'd4, 32'd21);

`ifdef MULT_STREAM_ACC_EN
        // Accumulation: first beat restarts, second adds on
        inAccClr = 1'b1;
        runSingle("acc_2x3", 16'd2, 16'd3, 1'b0, 4'd1, 32'd6);
        inAccClr = 1'b0;
        runSingle("acc_4x5", 16'd4, 16'd5, 1'b0, 4'd2, 32'd26);
        inAccClr = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
